// File: rtl/alu_dispatch.sv
// alu_dispatch: issue stage for the registered 8-bit ALU with credit-limited response FIFO.
// Optional build macro ALU_DISPATCH_STATS_EN adds OP_COUNT / STALL_COUNT statistics ports.
module alu_dispatch #(
    parameter int FIFO_DEPTH = 4,
    parameter int OP_W       = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic [7:0]      REQ_A,
    input  logic [7:0]      REQ_B,
    input  logic [OP_W-1:0] REQ_OP,
    output logic [7:0]      ALU_IN_A,
    output logic [7:0]      ALU_IN_B,
    output logic [OP_W-1:0] ALU_OP_CODE,
    input  logic [7:0]      ALU_RESULT,
    output logic            RSP_VALID,
    input  logic            RSP_READY,
    output logic [7:0]      RSP_RESULT,
    output logic [OP_W-1:0] RSP_OP,
`ifdef ALU_DISPATCH_STATS_EN
    output logic [15:0]     OP_COUNT,
    output logic [15:0]     STALL_COUNT,
`endif
    output logic            RSP_ZERO
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic            s1_v, s2_v;
    logic [OP_W-1:0] s2_op;
    logic [7:0]      res_mem [FIFO_DEPTH];
    logic [OP_W-1:0] op_mem  [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     cnt;
    logic [AW+1:0]   used;
    logic            accept, push, pop;

    // Credits count queued entries plus ops still travelling through the ALU.
    assign used      = (AW+2)'(cnt) + (AW+2)'(s1_v) + (AW+2)'(s2_v);
    assign REQ_READY = !RESET && (used < (AW+2)'(FIFO_DEPTH));
    assign accept    = REQ_VALID && REQ_READY;
    assign push      = s2_v;
    assign RSP_VALID = (cnt != '0);
    assign pop       = RSP_VALID && RSP_READY;
    assign RSP_RESULT = RSP_VALID ? res_mem[rd_ptr] : '0;
    assign RSP_OP     = RSP_VALID ? op_mem[rd_ptr] : '0;
    assign RSP_ZERO   = RSP_VALID && (res_mem[rd_ptr] == 8'h00);

    // Operand/op registers feed the ALU directly and double as the S1 tag; S2 tracks the ALU stage.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ALU_IN_A    <= '0;
            ALU_IN_B    <= '0;
            ALU_OP_CODE <= '1;
            s1_v        <= 1'b0;
            s2_v        <= 1'b0;
            s2_op       <= '0;
        end else begin
            s1_v  <= accept;
            s2_v  <= s1_v;
            s2_op <= ALU_OP_CODE;
            if (accept) begin
                ALU_IN_A    <= REQ_A;
                ALU_IN_B    <= REQ_B;
                ALU_OP_CODE <= REQ_OP;
            end
        end
    end

    // Response storage; no reset needed since the head is masked while empty.
    always_ff @(posedge CLK) begin
        if (push && !RESET) begin
            res_mem[wr_ptr] <= ALU_RESULT;
            op_mem[wr_ptr]  <= s2_op;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

`ifdef ALU_DISPATCH_STATS_EN
    logic stall;
    assign stall = REQ_VALID && !REQ_READY && !RESET;

    // Free-running wrap-around counters of accepted requests and blocked cycles.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            OP_COUNT    <= '0;
            STALL_COUNT <= '0;
        end else begin
            if (accept) OP_COUNT <= OP_COUNT + 16'd1;
            if (stall) STALL_COUNT <= STALL_COUNT + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: directed bench for alu_dispatch with a registered ALU model in the loop.
module tb_alu_dispatch;
    logic       CLK = 1'b0;
    logic       RESET, REQ_VALID, REQ_READY, RSP_VALID, RSP_READY, RSP_ZERO;
    logic [7:0] REQ_A, REQ_B, ALU_IN_A, ALU_IN_B, ALU_RESULT, RSP_RESULT;
    logic [3:0] REQ_OP, ALU_OP_CODE, RSP_OP;
`ifdef ALU_DISPATCH_STATS_EN
    logic [15:0] OP_COUNT, STALL_COUNT;
`endif
    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    alu_dispatch dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_OP(REQ_OP),
        .ALU_IN_A(ALU_IN_A), .ALU_IN_B(ALU_IN_B), .ALU_OP_CODE(ALU_OP_CODE),
        .ALU_RESULT(ALU_RESULT),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_RESULT(RSP_RESULT), .RSP_OP(RSP_OP),
`ifdef ALU_DISPATCH_STATS_EN
        .OP_COUNT(OP_COUNT), .STALL_COUNT(STALL_COUNT),
`endif
        .RSP_ZERO(RSP_ZERO)
    );

    // Registered ALU: add, sub, mul (truncated), equality, otherwise pass A.
    always_ff @(posedge CLK) begin
        case (ALU_OP_CODE)
            4'h0:    ALU_RESULT <= ALU_IN_A + ALU_IN_B;
            4'h1:    ALU_RESULT <= ALU_IN_A - ALU_IN_B;
            4'h2:    ALU_RESULT <= ALU_IN_A * ALU_IN_B;
            4'h9:    ALU_RESULT <= {7'b0, ALU_IN_A == ALU_IN_B};
            default: ALU_RESULT <= ALU_IN_A;
        endcase
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic req(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        REQ_VALID = v;
        REQ_A     = a;
        REQ_B     = b;
        REQ_OP    = op;
    endtask

    task automatic head(input string tag, input logic [7:0] r, input logic [3:0] op, input logic z);
        chk({tag, "_valid"}, 16'(RSP_VALID), 16'h1);
        chk({tag, "_result"}, 16'(RSP_RESULT), 16'(r));
        chk({tag, "_op"}, 16'(RSP_OP), 16'(op));
        chk({tag, "_zero"}, 16'(RSP_ZERO), 16'(z));
    endtask

    initial begin
        RESET = 1'b1;
        RSP_READY = 1'b0;
        req(0, 8'h00, 8'h00, 4'h0);
        repeat (2) @(posedge CLK);
        #1; #4;
        chk("rst_ready", 16'(REQ_READY), 16'h0);
        chk("rst_rsp_valid", 16'(RSP_VALID), 16'h0);
        chk("rst_op_code", 16'(ALU_OP_CODE), 16'hF);
        chk("rst_in_a", 16'(ALU_IN_A), 16'h0);
        chk("rst_in_b", 16'(ALU_IN_B), 16'h0);
        chk("rst_rsp_result", 16'(RSP_RESULT), 16'h0);
        chk("rst_rsp_op", 16'(RSP_OP), 16'h0);
        chk("rst_rsp_zero", 16'(RSP_ZERO), 16'h0);
        // single add, 2-cycle latency
        cyc(); RESET = 1'b0; RSP_READY = 1'b1; req(1, 8'h05, 8'h03, 4'h0); #4;
        chk("t1_ready", 16'(REQ_READY), 16'h1);
        cyc(); REQ_VALID = 1'b0; #4;
        chk("t1_in_a", 16'(ALU_IN_A), 16'h05);
        chk("t1_in_b", 16'(ALU_IN_B), 16'h03);
        chk("t1_op_code", 16'(ALU_OP_CODE), 16'h0);
        chk("t1_lat1_valid", 16'(RSP_VALID), 16'h0);
        cyc(); #4;
        chk("t1_lat2_valid", 16'(RSP_VALID), 16'h0);
        cyc(); #4;
        head("t1", 8'h08, 4'h0, 1'b0);
        cyc(); #4;
        chk("t1_popped", 16'(RSP_VALID), 16'h0);
        chk("t1_hold_a", 16'(ALU_IN_A), 16'h05);
        // back-to-back, one response per cycle
        cyc(); req(1, 8'h05, 8'h05, 4'h1); #4;
        chk("t2_ready0", 16'(REQ_READY), 16'h1);
        cyc(); req(1, 8'h10, 8'h10, 4'h2); #4;
        chk("t2_ready1", 16'(REQ_READY), 16'h1);
        cyc(); req(1, 8'h07, 8'h07, 4'h9); #4;
        chk("t2_ready2", 16'(REQ_READY), 16'h1);
        cyc(); REQ_VALID = 1'b0; #4;
        head("t2_sub", 8'h00, 4'h1, 1'b1);
        cyc(); #4;
        head("t2_mul", 8'h00, 4'h2, 1'b1);
        cyc(); #4;
        head("t2_eq", 8'h01, 4'h9, 1'b0);
        cyc(); #4;
        chk("t2_empty", 16'(RSP_VALID), 16'h0);
        // stalled consumer: exactly four accepted
        cyc(); RSP_READY = 1'b0; req(1, 8'h20, 8'h01, 4'h0); #4;
        chk("t3_ready0", 16'(REQ_READY), 16'h1);
        cyc(); req(1, 8'h30, 8'h01, 4'h1); #4;
        chk("t3_ready1", 16'(REQ_READY), 16'h1);
        cyc(); req(1, 8'h03, 8'h04, 4'h2); #4;
        chk("t3_ready2", 16'(REQ_READY), 16'h1);
        cyc(); req(1, 8'h03, 8'h04, 4'h9); #4;
        chk("t3_ready3", 16'(REQ_READY), 16'h1);
        cyc(); req(1, 8'h55, 8'h00, 4'h0); #4;
        chk("t3_full_ready", 16'(REQ_READY), 16'h0);
        cyc(); #4;
        chk("t3_full_ready_b", 16'(REQ_READY), 16'h0);
        cyc(); cyc(); #4;
        chk("t3_full_ready_c", 16'(REQ_READY), 16'h0);
        head("t3_head", 8'h21, 4'h0, 1'b0);
        // one pop from full, one new accept
        RSP_READY = 1'b1;
        cyc(); RSP_READY = 1'b0; #4;
        chk("t4_ready_after_pop", 16'(REQ_READY), 16'h1);
        head("t4_head", 8'h2F, 4'h1, 1'b0);
        cyc(); REQ_VALID = 1'b0; #4;
        chk("t4_ready_refull", 16'(REQ_READY), 16'h0);
        cyc(); cyc(); RSP_READY = 1'b1; #4;
        head("t4_d0", 8'h2F, 4'h1, 1'b0);
        cyc(); #4;
        head("t4_d1", 8'h0C, 4'h2, 1'b0);
        cyc(); #4;
        head("t4_d2", 8'h00, 4'h9, 1'b1);
        cyc(); #4;
        head("t4_d3", 8'h55, 4'h0, 1'b0);
        cyc(); #4;
        chk("t4_empty", 16'(RSP_VALID), 16'h0);
        // reset with two queued and two in flight
        cyc(); RSP_READY = 1'b0; req(1, 8'h01, 8'h01, 4'h0);
        cyc(); req(1, 8'h02, 8'h02, 4'h0);
        cyc(); req(1, 8'h03, 8'h03, 4'h0);
        cyc(); req(1, 8'h04, 8'h04, 4'h0);
        cyc(); #4;
        chk("t5_pre_valid", 16'(RSP_VALID), 16'h1);
        chk("t5_pre_ready", 16'(REQ_READY), 16'h0);
        RESET = 1'b1; REQ_VALID = 1'b0; #1;
        chk("t5_ready_in_reset", 16'(REQ_READY), 16'h0);
        cyc(); RESET = 1'b0; RSP_READY = 1'b1; #4;
        chk("t5_valid_after", 16'(RSP_VALID), 16'h0);
        chk("t5_op_code", 16'(ALU_OP_CODE), 16'hF);
        chk("t5_result", 16'(RSP_RESULT), 16'h0);
        cyc(); cyc(); cyc(); #4;
        chk("t5_no_stale", 16'(RSP_VALID), 16'h0);
        chk("t5_ready", 16'(REQ_READY), 16'h1);
        // truncating add after reset
        cyc(); req(1, 8'hFF, 8'h01, 4'h0);
        cyc(); REQ_VALID = 1'b0;
        cyc(); cyc(); #4;
        head("t6_wrap", 8'h00, 4'h0, 1'b1);
`ifdef ALU_DISPATCH_STATS_EN
        cyc(); RESET = 1'b1; REQ_VALID = 1'b0;
        cyc(); RESET = 1'b0; RSP_READY = 1'b0; req(1, 8'h01, 8'h02, 4'h0);
        repeat (9) cyc();
        REQ_VALID = 1'b0; RSP_READY = 1'b1;
        repeat (6) cyc();
        REQ_VALID = 1'b1;
        repeat (6) cyc();
        REQ_VALID = 1'b0; #4;
        chk("st_op_count", OP_COUNT, 16'd10);
        chk("st_stall_count", STALL_COUNT, 16'd5);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
